// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a built-in sequential
// clear engine. Entry 0 reads as zero. Two write ports (0 = WB, 1 = late
// MUL/DIV writeback); port 1 wins when both hit the same entry.
// Optional macro REG_FILE_MP_BYPASS_EN forwards same-cycle write data to reads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing entry[idx_q] each cycle, idx 1..NREGS-1; reads return 0
// S_READY | normal operation; init_done_o high, writes accepted
module reg_file_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int NREAD = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_req_i,
   output logic                  init_done_o,
   input  logic [NREAD*AW-1:0]   rs_addr_i,
   output logic [NREAD*XLEN-1:0] rs_data_o,
   input  logic [1:0]            wr_en_i,
   input  logic [2*AW-1:0]       wr_addr_i,
   input  logic [2*XLEN-1:0]     wr_data_i,
   output logic                  wr_conflict_o
);

   typedef enum logic {S_CLEAR, S_READY} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            wr_conflict_q, wr_conflict_d;
   logic            clear_en;
   logic            wr_ok;
   logic            we0, we1;
   logic [AW-1:0]   wa0, wa1;
   logic [XLEN-1:0] wd0, wd1;
   logic [XLEN-1:0] mem_q [NREGS];

   assign wa0 = wr_addr_i[0 +: AW];
   assign wa1 = wr_addr_i[AW +: AW];
   assign wd0 = wr_data_i[0 +: XLEN];
   assign wd1 = wr_data_i[XLEN +: XLEN];

   // state, clear index and conflict flag registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_CLEAR;
         idx_q         <= AW'(1);
         wr_conflict_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   // next state: walk the clear index, then accept clear requests in READY
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_CLEAR: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREGS - 1)) state_d = S_READY;
         end
         S_READY: begin
            if (clr_req_i) begin
               state_d = S_CLEAR;
               idx_d   = AW'(1);
            end
         end
      endcase
   end

   // outputs and write qualification; rst beats clr_req beats writes
   always_comb begin
      init_done_o   = (state_q == S_READY);
      clear_en      = (state_q == S_CLEAR) && !rst_i;
      wr_ok         = (state_q == S_READY) && !clr_req_i && !rst_i;
      we0           = wr_ok && wr_en_i[0] && (wa0 != '0);
      we1           = wr_ok && wr_en_i[1] && (wa1 != '0);
      wr_conflict_d = we0 && we1 && (wa0 == wa1);
   end

   assign wr_conflict_o = wr_conflict_q;

   // storage: clear engine, then late port, then WB port; entry 0 never stored
   always_ff @(posedge clk_i) begin
      for (int i = 1; i < NREGS; i++) begin
         if (clear_en && (idx_q == AW'(i))) begin
            mem_q[i] <= '0;
         end else if (we1 && (wa1 == AW'(i))) begin
            mem_q[i] <= wd1;
         end else if (we0 && (wa0 == AW'(i))) begin
            mem_q[i] <= wd0;
         end
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;

      assign ra = rs_addr_i[k*AW +: AW];

      // read mux: zero for x0 and while clearing
      always_comb begin
         rd = '0;
         if ((state_q == S_READY) && (ra != '0)) begin
            rd = mem_q[ra];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_en_i[1] && (wa1 == ra)) begin
               rd = wd1;
            end else if (wr_en_i[0] && (wa0 == ra)) begin
               rd = wd0;
            end
`endif
         end
      end

      assign rs_data_o[k*XLEN +: XLEN] = rd;
   end

endmodule
